// File: rtl/mm_timer.sv
// mm_timer: memory-mapped 64-bit machine timer with prescaler, compare
// register, level timer interrupt and interrupt-acknowledge counter.
//
// Parameters:
//   BASE_ADDR  - word-aligned base of the 32-byte register window
//   ACK_IRQ_ID - irq_id_i value that counts as a timer-irq acknowledge
// Ports:
//   clk_i, rst_ni              - clock, synchronous active-low reset
//   data_addr_i/we_i/be_i/wdata_i - core data-port write/read request
//   data_sel_o                 - combinational window hit
//   data_rdata_o               - read data, one cycle after the request
//   irq_id_i, irq_ack_i        - interrupt acknowledge from the core
//   irq_timer_o                - registered level timer interrupt
// Optional build macro: MM_TIMER_AUTORELOAD_EN enables the PERIOD
// register and the compare auto-reload on each counted acknowledge.
module mm_timer #(
    parameter logic [31:0] BASE_ADDR  = 32'h1500_0000,
    parameter logic [4:0]  ACK_IRQ_ID = 5'd7
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] data_addr_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_sel_o,
    output logic [31:0] data_rdata_o,
    input  logic [4:0]  irq_id_i,
    input  logic        irq_ack_i,
    output logic        irq_timer_o
);

    logic [63:0] mtime_q, mtime_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic        en_q;
    logic [7:0]  prescale_q;
    logic [7:0]  pcnt_q;
    logic [7:0]  ack_cnt_q;
    logic [31:0] period_q;
    logic        irq_q;
    logic [31:0] rdata_q;
    logic [31:0] rd_mux;

    logic [2:0]  reg_idx;
    logic        wr;
    logic        wr_tlo, wr_thi, wr_clo, wr_chi;
    logic        wr_ctrl, wr_status;
    logic        tick;
    logic        ack_hit;
    logic        unused_addr;

    function automatic logic [31:0] merge(
        input logic [31:0] old,
        input logic [31:0] wd,
        input logic [3:0]  be
    );
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++)
            if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
        return r;
    endfunction

    assign data_sel_o  = (data_addr_i[31:5] == BASE_ADDR[31:5]);
    assign reg_idx     = data_addr_i[4:2];
    assign unused_addr = ^data_addr_i[1:0];

    assign wr        = data_we_i && data_sel_o;
    assign wr_tlo    = wr && (reg_idx == 3'd0);
    assign wr_thi    = wr && (reg_idx == 3'd1);
    assign wr_clo    = wr && (reg_idx == 3'd2);
    assign wr_chi    = wr && (reg_idx == 3'd3);
    assign wr_ctrl   = wr && (reg_idx == 3'd4);
    assign wr_status = wr && (reg_idx == 3'd5);

    assign tick    = en_q && (pcnt_q == prescale_q);
    assign ack_hit = irq_ack_i && (irq_id_i == ACK_IRQ_ID);

    // A bus write to either mtime half overrides the tick entirely.
    always_comb begin
        mtime_d = mtime_q;
        if (wr_tlo || wr_thi) begin
            if (wr_tlo)
                mtime_d[31:0] = merge(mtime_q[31:0], data_wdata_i, data_be_i);
            if (wr_thi)
                mtime_d[63:32] = merge(mtime_q[63:32], data_wdata_i, data_be_i);
        end else if (tick) begin
            mtime_d = mtime_q + 64'd1;
        end
    end

    // A bus write to either compare half cancels any auto-reload.
    always_comb begin
        mtimecmp_d = mtimecmp_q;
        if (wr_clo || wr_chi) begin
            if (wr_clo)
                mtimecmp_d[31:0] = merge(mtimecmp_q[31:0], data_wdata_i, data_be_i);
            if (wr_chi)
                mtimecmp_d[63:32] = merge(mtimecmp_q[63:32], data_wdata_i, data_be_i);
        end
`ifdef MM_TIMER_AUTORELOAD_EN
        else if (ack_hit && (period_q != 32'd0)) begin
            mtimecmp_d = mtimecmp_q + {32'd0, period_q};
        end
`endif
    end

    always_comb begin
        case (reg_idx)
            3'd0:    rd_mux = mtime_q[31:0];
            3'd1:    rd_mux = mtime_q[63:32];
            3'd2:    rd_mux = mtimecmp_q[31:0];
            3'd3:    rd_mux = mtimecmp_q[63:32];
            3'd4:    rd_mux = {16'd0, prescale_q, 7'd0, en_q};
            3'd5:    rd_mux = {16'd0, ack_cnt_q, 7'd0, irq_q};
            3'd6:    rd_mux = period_q;
            default: rd_mux = 32'd0;
        endcase
    end

`ifdef MM_TIMER_AUTORELOAD_EN
    always_ff @(posedge clk_i) begin
        if (!rst_ni)
            period_q <= 32'd0;
        else if (wr && (reg_idx == 3'd6))
            period_q <= merge(period_q, data_wdata_i, data_be_i);
    end
`else
    assign period_q = 32'd0;
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            mtime_q    <= 64'd0;
            mtimecmp_q <= '1;
            en_q       <= 1'b0;
            prescale_q <= 8'd0;
            pcnt_q     <= 8'd0;
            ack_cnt_q  <= 8'd0;
            irq_q      <= 1'b0;
            rdata_q    <= 32'd0;
        end else begin
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            irq_q      <= en_q && (mtime_q >= mtimecmp_q);
            rdata_q    <= data_sel_o ? rd_mux : 32'd0;

            if (wr_ctrl) begin
                if (data_be_i[0]) en_q <= data_wdata_i[0];
                if (data_be_i[1]) prescale_q <= data_wdata_i[15:8];
            end

            // Prescaler restarts on CTRL or mtime writes and idles at 0.
            if (wr_ctrl || wr_tlo || wr_thi || !en_q || tick)
                pcnt_q <= 8'd0;
            else
                pcnt_q <= pcnt_q + 8'd1;

            if (wr_status)
                ack_cnt_q <= 8'd0;
            else if (ack_hit && (ack_cnt_q != 8'hFF))
                ack_cnt_q <= ack_cnt_q + 8'd1;
        end
    end

    assign data_rdata_o = rdata_q;
    assign irq_timer_o  = irq_q;

endmodule

// File: tb/tb_mm_timer.sv
// tb_mm_timer: randomized scoreboard bench for mm_timer.
// A reference model predicts read data and irq; a monitor compares.
module tb_mm_timer;

    localparam logic [31:0] BASE = 32'h1500_0000;

    logic        clk_i;
    logic        rst_ni;
    logic [31:0] data_addr_i;
    logic        data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_wdata_i;
    logic        data_sel_o;
    logic [31:0] data_rdata_o;
    logic [4:0]  irq_id_i;
    logic        irq_ack_i;
    logic        irq_timer_o;

    mm_timer #(
        .BASE_ADDR (BASE),
        .ACK_IRQ_ID(5'd7)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .data_addr_i (data_addr_i),
        .data_we_i   (data_we_i),
        .data_be_i   (data_be_i),
        .data_wdata_i(data_wdata_i),
        .data_sel_o  (data_sel_o),
        .data_rdata_o(data_rdata_o),
        .irq_id_i    (irq_id_i),
        .irq_ack_i   (irq_ack_i),
        .irq_timer_o (irq_timer_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [31:0] rd;
        logic        irq;
        logic        ck;
        logic [31:0] av;
        logic [31:0] am;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model state: plain values plus "cycles until next tick".
    logic [63:0] m_time, m_cmp;
    logic        m_en, m_irq;
    logic [7:0]  m_ps, m_ack;
    logic [31:0] m_period;
    int          m_left;

    function automatic logic [31:0] bmerge(
        input logic [31:0] old, input logic [31:0] wd, input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++)
            if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] mread(input int off);
        case (off)
            0: return m_time[31:0];
            1: return m_time[63:32];
            2: return m_cmp[31:0];
            3: return m_cmp[63:32];
            4: return {16'd0, m_ps, 7'd0, m_en};
            5: return {16'd0, m_ack, 7'd0, m_irq};
            6: return m_period;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_step(
        input logic r, input logic [31:0] a, input logic w,
        input logic [3:0] be, input logic [31:0] wd,
        input logic ak, input logic [4:0] id,
        output logic [31:0] erd, output logic eirq);
        logic hit, tick, wt, cack, restart;
        int   off;
        if (!r) begin
            m_time = 64'd0; m_cmp = '1; m_en = 1'b0; m_ps = 8'd0;
            m_ack = 8'd0; m_period = 32'd0; m_irq = 1'b0; m_left = 1;
            erd = 32'd0; eirq = 1'b0;
            return;
        end
        hit  = (a[31:5] == BASE[31:5]);
        off  = int'(a[4:2]);
        erd  = hit ? mread(off) : 32'd0;
        eirq = m_en && (m_time >= m_cmp);
        wt   = w && hit;
        cack = ak && (id == 5'd7);
        tick = 1'b0;
        restart = 1'b0;
        if (m_en) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                tick = 1'b1;
                restart = 1'b1;
            end
        end
        if (wt && (off == 0 || off == 1)) begin
            if (off == 0) m_time[31:0]  = bmerge(m_time[31:0], wd, be);
            else          m_time[63:32] = bmerge(m_time[63:32], wd, be);
            restart = 1'b1;
        end else if (tick) begin
            m_time = m_time + 64'd1;
        end
        if (wt && (off == 2 || off == 3)) begin
            if (off == 2) m_cmp[31:0]  = bmerge(m_cmp[31:0], wd, be);
            else          m_cmp[63:32] = bmerge(m_cmp[63:32], wd, be);
        end
`ifdef MM_TIMER_AUTORELOAD_EN
        else if (cack && m_period != 32'd0) begin
            m_cmp = m_cmp + {32'd0, m_period};
        end
        if (wt && off == 6) m_period = bmerge(m_period, wd, be);
`endif
        if (wt && off == 4) begin
            if (be[0]) m_en = wd[0];
            if (be[1]) m_ps = wd[15:8];
            restart = 1'b1;
        end
        if (wt && off == 5) m_ack = 8'd0;
        else if (cack && m_ack != 8'hFF) m_ack = m_ack + 8'd1;
        if (restart || !m_en) m_left = int'(m_ps) + 1;
        m_irq = eirq;
    endtask

    // Drive one cycle and push the model's prediction for the next edge.
    task automatic cyc(
        input logic r, input logic [31:0] a, input logic w,
        input logic [3:0] be, input logic [31:0] wd,
        input logic ak, input logic [4:0] id,
        input logic ck, input logic [31:0] av, input logic [31:0] am);
        exp_t e;
        logic [31:0] erd;
        logic eirq;
        @(negedge clk_i);
        rst_ni = r; data_addr_i = a; data_we_i = w; data_be_i = be;
        data_wdata_i = wd; irq_ack_i = ak; irq_id_i = id;
        model_step(r, a, w, be, wd, ak, id, erd, eirq);
        e.rd = erd; e.irq = eirq; e.ck = ck; e.av = av; e.am = am;
        exp_q.push_back(e);
    endtask

    task automatic wr(input int off, input logic [31:0] d);
        cyc(1'b1, BASE + 32'(4 * off), 1'b1, 4'hF, d, 1'b0, 5'd0,
            1'b0, 32'd0, 32'd0);
    endtask

    task automatic rdc(input int off, input logic [31:0] v, input logic [31:0] m);
        cyc(1'b1, BASE + 32'(4 * off), 1'b0, 4'h0, 32'd0, 1'b0, 5'd0,
            1'b1, v, m);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            cyc(1'b1, 32'h0, 1'b0, 4'h0, 32'd0, 1'b0, 5'd0,
                1'b0, 32'd0, 32'd0);
    endtask

    task automatic ack(input logic [4:0] id);
        cyc(1'b1, 32'h0, 1'b0, 4'h0, 32'd0, 1'b1, id,
            1'b0, 32'd0, 32'd0);
    endtask

    // Monitor: one prediction per clock edge, sampled 1 unit after it.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk_i);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_tests++;
                if (data_rdata_o !== e.rd) begin
                    n_fail++;
                    $display("FAIL rdata: got %h expected %h at %0t",
                             data_rdata_o, e.rd, $time);
                end
                n_tests++;
                if (irq_timer_o !== e.irq) begin
                    n_fail++;
                    $display("FAIL irq: got %b expected %b at %0t",
                             irq_timer_o, e.irq, $time);
                end
                if (e.ck) begin
                    n_tests++;
                    if ((data_rdata_o & e.am) !== e.av) begin
                        n_fail++;
                        $display("FAIL abs_read: got %h expected %h mask %h at %0t",
                                 data_rdata_o, e.av, e.am, $time);
                    end
                end
            end
        end
    end

    initial begin
        logic [31:0] a, d;
        logic [3:0]  be;
        int          k;
        rst_ni = 1'b0; data_addr_i = 32'd0; data_we_i = 1'b0;
        data_be_i = 4'd0; data_wdata_i = 32'd0;
        irq_ack_i = 1'b0; irq_id_i = 5'd0;

        for (int i = 0; i < 3; i++)
            cyc(1'b0, 32'h0, 1'b0, 4'h0, 32'd0, 1'b0, 5'd0,
                1'b0, 32'd0, 32'd0);

        // Reset values of every register.
        rdc(0, 32'd0, '1);
        rdc(1, 32'd0, '1);
        rdc(2, 32'hFFFF_FFFF, '1);
        rdc(3, 32'hFFFF_FFFF, '1);
        rdc(4, 32'd0, '1);
        rdc(5, 32'd0, '1);
        rdc(6, 32'd0, '1);
        rdc(7, 32'd0, '1);

        // PRESCALE=3: ten ticks in forty enabled cycles.
        wr(0, 32'd0);
        wr(1, 32'd0);
        wr(4, 32'h0000_0301);
        idle(40);
        rdc(0, 32'd10, '1);
        wr(4, 32'h0000_0001);
        idle(5);
        rdc(0, 32'd0, 32'd0);
        rdc(0, 32'd0, 32'd0);
        wr(4, 32'd0);

        // Carry into the high word, then full 64-bit wrap.
        wr(0, 32'hFFFF_FFFE);
        wr(1, 32'd0);
        wr(4, 32'h1);
        idle(1);
        wr(4, 32'h0);
        rdc(0, 32'd0, '1);
        rdc(1, 32'd1, '1);
        wr(0, 32'hFFFF_FFFF);
        wr(1, 32'hFFFF_FFFF);
        wr(4, 32'h1);
        wr(4, 32'h0);
        rdc(0, 32'd0, '1);
        rdc(1, 32'd0, '1);

        // Compare at 20, then raise compare to 100.
        wr(0, 32'd0);
        wr(1, 32'd0);
        wr(2, 32'd20);
        wr(3, 32'd0);
        wr(4, 32'h1);
        idle(19);
        rdc(5, 32'd0, 32'h1);
        idle(2);
        rdc(5, 32'd1, 32'h1);
        wr(2, 32'd100);
        idle(3);
        wr(4, 32'h0);

        // Acknowledge counting, saturation and write-wins clear.
        wr(5, 32'd0);
        ack(5'd7); ack(5'd7); ack(5'd3); ack(5'd7);
        rdc(5, 32'h0000_0300, 32'h0000_FF00);
        for (int i = 0; i < 300; i++) ack(5'd7);
        rdc(5, 32'h0000_FF00, 32'h0000_FF00);
        cyc(1'b1, BASE + 32'h14, 1'b1, 4'hF, 32'd0, 1'b1, 5'd7,
            1'b0, 32'd0, 32'd0);
        rdc(5, 32'd0, 32'h0000_FF00);

        // Byte-enable write and reserved/outside-window accesses.
        cyc(1'b1, BASE + 32'h8, 1'b1, 4'b0100, 32'h00AB_0000, 1'b0, 5'd0,
            1'b0, 32'd0, 32'd0);
        rdc(2, 32'h00AB_0064, '1);
        wr(7, 32'hDEAD_BEEF);
        rdc(7, 32'd0, '1);
        cyc(1'b1, BASE + 32'h20, 1'b1, 4'hF, 32'h1234_5678, 1'b0, 5'd0,
            1'b0, 32'd0, 32'd0);
        rdc(2, 32'h00AB_0064, '1);

`ifdef MM_TIMER_AUTORELOAD_EN
        wr(0, 32'd0);
        wr(1, 32'd0);
        wr(6, 32'd50);
        wr(2, 32'd20);
        wr(3, 32'd0);
        wr(4, 32'h1);
        idle(24);
        ack(5'd7);
        rdc(2, 32'd70, '1);
        idle(55);
        rdc(5, 32'd1, 32'h1);
        wr(4, 32'h0);
`endif

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            k = int'($urandom_range(0, 9));
            if (k < 8) a = BASE + 32'(4 * k) + 32'($urandom_range(0, 3));
            else if (k == 8) a = BASE + 32'h20 + 32'($urandom_range(0, 31));
            else a = $urandom;
            d  = $urandom;
            be = 4'($urandom_range(0, 15));
            if (k == 4 && $urandom_range(0, 1) == 1) d[15:8] = 8'($urandom_range(0, 3));
            if ((k == 2 || k == 0) && $urandom_range(0, 1) == 1) d[31:8] = 24'd0;
            if (k == 1 || k == 3) d = ($urandom_range(0, 3) == 0) ? d : 32'd0;
            cyc(($urandom_range(0, 699) != 0), a,
                ($urandom_range(0, 2) == 0), be, d,
                ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 1) == 1) ? 5'd7 : 5'($urandom_range(0, 31)),
                1'b0, 32'd0, 32'd0);
        end

        @(negedge clk_i);
        irq_ack_i = 1'b0;
        data_we_i = 1'b0;
        for (int i = 0; i < 10 && exp_q.size() > 0; i++)
            @(posedge clk_i);
        #2;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d predictions left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mm_timer.md
# mm_timer

Memory-mapped machine timer for the simulation testbench, sitting beside the RAM on the core's data bus and driving the core's timer interrupt line. It implements a 64-bit `mtime` counter with a programmable prescaler, a 64-bit `mtimecmp` compare register and a level timer interrupt. It also counts interrupt acknowledges so tests can check that the core took the interrupt.

## Interface
Parameters:
- `BASE_ADDR`, 32'h1500_0000, word-aligned base of the 32-byte register window.
- `ACK_IRQ_ID`, 5'd7, value of `irq_id_i` that identifies a timer-interrupt acknowledge.

Ports:
- `clk_i` in 1: single clock.
- `rst_ni` in 1: reset, synchronous, active-low.
- `data_addr_i` in 32: byte address from the core data port.
- `data_we_i` in 1: write strobe; a write occurs in any cycle where it is high and the address hits.
- `data_be_i` in 4: byte enables for writes.
- `data_wdata_i` in 32: write data.
- `data_sel_o` out 1: combinational hit, `data_addr_i[31:5] == BASE_ADDR[31:5]`.
- `data_rdata_o` out 32: registered read data.
- `irq_id_i` in 5: id of the interrupt being acknowledged.
- `irq_ack_i` in 1: acknowledge pulse.
- `irq_timer_o` out 1: registered level timer interrupt.

## Operation
Register map (offset from `BASE_ADDR`, 32-bit each):
- 0x00 `MTIME_LO`, 0x04 `MTIME_HI`: read/write.
- 0x08 `MTIMECMP_LO`, 0x0C `MTIMECMP_HI`: read/write.
- 0x10 `CTRL`: bit0 `EN`, bits[15:8] `PRESCALE`; other bits read 0.
- 0x14 `STATUS`: bit0 = current `irq_timer_o`; bits[15:8] = `ACK_CNT`. Any write clears `ACK_CNT`.
- 0x18 `PERIOD`: see Configuration.
- 0x1C: reserved; reads 0, writes ignored.

Write rules:
- Writes apply byte-wise per `data_be_i`.
- Addresses outside the window are ignored.

Prescaler and counter:
- An 8-bit prescale counter runs while `EN` is 1 and holds at 0 while `EN` is 0.
- When the prescale counter equals `PRESCALE`, it resets to 0 and `mtime` increments by 1, so `mtime` advances every `PRESCALE`+1 cycles.
- `mtime` is 64-bit unsigned and wraps from all-ones to 0.
- The carry from the low to the high word is internal to the increment; software reads of the two halves are not atomic.

Simultaneous events:
- A bus write to `MTIME_LO`/`MTIME_HI` in a tick cycle wins. The written bytes take the write data, the unwritten bytes keep their old value (no increment), and the prescaler is reset to 0.
- Writing `CTRL` resets the prescale counter to 0.

Compare and interrupt:
- Next-state irq is `EN && (mtime >= mtimecmp)`, a 64-bit unsigned compare of the current register values.
- `irq_timer_o` registers this next-state value.
- Acknowledge: `irq_ack_i && irq_id_i == ACK_IRQ_ID` increments `ACK_CNT`, which saturates at 255.
- An acknowledge does not clear the irq. Software clears it by raising `mtimecmp` or clearing `EN`.
- If an acknowledge and a `STATUS` write occur in the same cycle, the write wins and `ACK_CNT` becomes 0.

Reset values:
- `mtime` 0, `mtimecmp` all-ones, `CTRL` 0, `ACK_CNT` 0, `PERIOD` 0, prescale counter 0.
- `data_rdata_o` 0, `irq_timer_o` 0.
- Reset asserted mid-count returns all state to these values on the next clock edge.

## Timing
- Read latency is 1 cycle. `data_rdata_o` in cycle N+1 holds the register addressed in cycle N, or 0 if there was no hit. Reads have no side effects.
- A read and a write to the same register in the same cycle return the pre-write value.
- A write lands at the clock edge ending its cycle. The affected compare result appears on `irq_timer_o` one edge later, so the write-to-irq latency is 2 edges.
- A tick making `mtime == mtimecmp` raises `irq_timer_o` at the following edge.
- `ACK_CNT` updates at the edge ending the acknowledge cycle.

## Configuration
`MM_TIMER_AUTORELOAD_EN`:
- Defined:
  - `PERIOD` (0x18) is a 32-bit read/write register.
  - On each counted acknowledge with `PERIOD` != 0, `mtimecmp` <= `mtimecmp` + zero-extended `PERIOD`, with 64-bit wrap.
  - A same-cycle bus write to `mtimecmp` wins over the reload.
- Not defined: 0x18 reads 0, writes are ignored, and there is no reload logic.

## Test plan
- Reset, then read all registers: `MTIMECMP` = FFFF_FFFF in both words, all other registers 0, `irq_timer_o` = 0.
- Program `PRESCALE`=3, `EN`=1, and sample `MTIME_LO` after 40 cycles: the value is 10 (±1 for the write cycle). With `PRESCALE`=0, `mtime` increments every cycle.
- Write `MTIME` = 0000_0000_FFFF_FFFE with `PRESCALE`=0: it increments to 0000_0001_0000_0000 on the second tick. Then write `MTIME` to all-ones: it wraps to 0.
- Set `MTIMECMP`=20 and `EN`=1 from `mtime`=0 with `PRESCALE`=0: `irq_timer_o` rises exactly one edge after `mtime` reaches 20. Writing `MTIMECMP`=100 drops it 2 edges later.
- Pulse `irq_ack_i` with `irq_id_i`=7 three times and once with id 3: `ACK_CNT`=3. 300 acknowledges give 255. A `STATUS` write in the same cycle as an acknowledge gives 0.
- With `MM_TIMER_AUTORELOAD_EN` defined, set `PERIOD`=50 and `MTIMECMP`=20 and acknowledge at the irq: `MTIMECMP`=70, the irq drops, then re-rises at `mtime`=70.
